// File: rtl/tri_assemble_pkg.sv
// Shared types for triangle assembly: coordinate/area widths, vertex record, FSM states.
// No logic beyond small min/max helpers used by the area/bbox stage.
// Pure definitions, no flow control.
package tri_assemble_pkg;

    localparam int COORD_W = 9;
    localparam int AREA_W  = 21;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] z;
    } vertex_t;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_AREA    = 2'd1,
        ST_OUT     = 2'd2
    } state_e;

    function automatic logic [COORD_W-1:0] min3(input logic [COORD_W-1:0] a,
                                                input logic [COORD_W-1:0] b,
                                                input logic [COORD_W-1:0] c);
        logic [COORD_W-1:0] m;
        m = (a < b) ? a : b;
        return (c < m) ? c : m;
    endfunction

    function automatic logic [COORD_W-1:0] max3(input logic [COORD_W-1:0] a,
                                                input logic [COORD_W-1:0] b,
                                                input logic [COORD_W-1:0] c);
        logic [COORD_W-1:0] m;
        m = (a > b) ? a : b;
        return (c > m) ? c : m;
    endfunction

endpackage

// File: rtl/tri_area.sv
// Signed triangle area (twice the geometric area) and screen bounding box.
// Latency: combinational.
// Backpressure: none, pure function of the three stored vertices.
module tri_area
    import tri_assemble_pkg::*;
(
    input  logic [COORD_W-1:0]        x0,
    input  logic [COORD_W-1:0]        y0,
    input  logic [COORD_W-1:0]        x1,
    input  logic [COORD_W-1:0]        y1,
    input  logic [COORD_W-1:0]        x2,
    input  logic [COORD_W-1:0]        y2,
    output logic signed [AREA_W-1:0]  area,
    output logic [COORD_W-1:0]        min_x,
    output logic [COORD_W-1:0]        min_y,
    output logic [COORD_W-1:0]        max_x,
    output logic [COORD_W-1:0]        max_y
);

    localparam int PROD_W = 2 * (COORD_W + 1);

    logic signed [COORD_W:0]   dx1, dy1, dx2, dy2;
    logic signed [PROD_W-1:0]  p_a, p_b;

    // Zero-extend before subtracting so full 9-bit unsigned range stays exact.
    assign dx1 = $signed({1'b0, x1}) - $signed({1'b0, x0});
    assign dy1 = $signed({1'b0, y1}) - $signed({1'b0, y0});
    assign dx2 = $signed({1'b0, x2}) - $signed({1'b0, x0});
    assign dy2 = $signed({1'b0, y2}) - $signed({1'b0, y0});

    assign p_a  = PROD_W'(dx1) * PROD_W'(dy2);
    assign p_b  = PROD_W'(dx2) * PROD_W'(dy1);
    assign area = AREA_W'(p_a) - AREA_W'(p_b);

    assign min_x = min3(x0, x1, x2);
    assign min_y = min3(y0, y1, y2);
    assign max_x = max3(x0, x1, x2);
    assign max_y = max3(y0, y1, y2);

endmodule

// File: rtl/tri_assemble.sv
// Groups vertices into triangles, culls degenerate/back-facing ones, emits bbox + vertices.
// Latency: third vertex accepted in cycle N -> valid_out in cycle N+2; one triangle per 5 cycles.
// Backpressure: holds the transaction until ready_in; ready_out is low outside collection.
module tri_assemble
    import tri_assemble_pkg::*;
#(
    parameter bit CULL_BACK = 1'b1
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic [2:0][COORD_W-1:0]  coor_in,
    input  logic                     valid_in,
    input  logic                     obj_done_in,
    output logic                     ready_out,
    output logic [2:0][COORD_W-1:0]  tri_x_out,
    output logic [2:0][COORD_W-1:0]  tri_y_out,
    output logic [2:0][COORD_W-1:0]  tri_z_out,
    output logic [1:0][COORD_W-1:0]  bbox_min_out,
    output logic [1:0][COORD_W-1:0]  bbox_max_out,
    output logic                     tri_keep_out,
    output logic                     obj_done_out,
    output logic                     valid_out,
    input  logic                     ready_in
);

    state_e                    state;
    logic [1:0]                idx;
    vertex_t [2:0]             vtx_q;
    logic                      last_done;
    logic signed [AREA_W-1:0]  area;
    logic [COORD_W-1:0]        min_x, min_y, max_x, max_y;
    logic                      drop;

    tri_area u_area (
        .x0    (vtx_q[0].x),
        .y0    (vtx_q[0].y),
        .x1    (vtx_q[1].x),
        .y1    (vtx_q[1].y),
        .x2    (vtx_q[2].x),
        .y2    (vtx_q[2].y),
        .area  (area),
        .min_x (min_x),
        .min_y (min_y),
        .max_x (max_x),
        .max_y (max_y)
    );

    assign drop      = (area == '0) || (CULL_BACK && (area < 0));
    assign ready_out = (state == ST_COLLECT);
    assign valid_out = (state == ST_OUT);

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            tri_x_out[i] = vtx_q[i].x;
            tri_y_out[i] = vtx_q[i].y;
            tri_z_out[i] = vtx_q[i].z;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state        <= ST_COLLECT;
            idx          <= 2'd0;
            vtx_q        <= '0;
            last_done    <= 1'b0;
            bbox_min_out <= '0;
            bbox_max_out <= '0;
            tri_keep_out <= 1'b0;
            obj_done_out <= 1'b0;
        end else begin
            case (state)
                ST_COLLECT: begin
                    if (valid_in) begin
                        for (int i = 0; i < 3; i++) begin
                            if (idx == 2'(i)) begin
                                vtx_q[i] <= '{x: coor_in[2], y: coor_in[1], z: coor_in[0]};
                            end
                        end
                        // An object ending on vertex 0 or 1 yields only an end marker.
                        if (obj_done_in && idx != 2'd2) begin
                            idx          <= 2'd0;
                            tri_keep_out <= 1'b0;
                            obj_done_out <= 1'b1;
                            state        <= ST_OUT;
                        end else if (idx == 2'd2) begin
                            idx       <= 2'd0;
                            last_done <= obj_done_in;
                            state     <= ST_AREA;
                        end else begin
                            idx <= idx + 2'd1;
                        end
                    end
                end
                ST_AREA: begin
                    bbox_min_out <= {min_x, min_y};
                    bbox_max_out <= {max_x, max_y};
                    if (!drop) begin
                        tri_keep_out <= 1'b1;
                        obj_done_out <= last_done;
                        state        <= ST_OUT;
                    end else if (last_done) begin
                        tri_keep_out <= 1'b0;
                        obj_done_out <= 1'b1;
                        state        <= ST_OUT;
                    end else begin
                        state <= ST_COLLECT;
                    end
                end
                ST_OUT: begin
                    if (ready_in) begin
                        state <= ST_COLLECT;
                    end
                end
                default: state <= ST_COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_tri_assemble.sv
// Scoreboard bench for tri_assemble: two instances (culling on/off) share stimulus.
module tb_tri_assemble;

    logic            clk_in = 1'b0;
    logic            rst_in = 1'b0;
    logic [2:0][8:0] coor_in = '0;
    logic            valid_in = 1'b0;
    logic            obj_done_in = 1'b0;
    logic            ready_in = 1'b1;

    logic            ra, va, ka, oa;
    logic [2:0][8:0] txa, tya, tza;
    logic [1:0][8:0] bmina, bmaxa;
    logic            rb, vb, kb, ob;
    logic [2:0][8:0] txb, tyb, tzb;
    logic [1:0][8:0] bminb, bmaxb;

    typedef struct packed {
        logic [2:0][8:0] x, y, z;
        logic [1:0][8:0] bmin, bmax;
        logic            keep, od;
    } txn_t;

    txn_t q_a[$];
    txn_t q_b[$];
    txn_t act_a, act_b;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk_in = ~clk_in;

    tri_assemble #(.CULL_BACK(1'b1)) dut_a (
        .clk_in(clk_in), .rst_in(rst_in), .coor_in(coor_in), .valid_in(valid_in),
        .obj_done_in(obj_done_in), .ready_out(ra), .tri_x_out(txa), .tri_y_out(tya),
        .tri_z_out(tza), .bbox_min_out(bmina), .bbox_max_out(bmaxa), .tri_keep_out(ka),
        .obj_done_out(oa), .valid_out(va), .ready_in(ready_in)
    );

    tri_assemble #(.CULL_BACK(1'b0)) dut_b (
        .clk_in(clk_in), .rst_in(rst_in), .coor_in(coor_in), .valid_in(valid_in),
        .obj_done_in(obj_done_in), .ready_out(rb), .tri_x_out(txb), .tri_y_out(tyb),
        .tri_z_out(tzb), .bbox_min_out(bminb), .bbox_max_out(bmaxb), .tri_keep_out(kb),
        .obj_done_out(ob), .valid_out(vb), .ready_in(ready_in)
    );

    always_comb begin
        act_a = '{x: txa, y: tya, z: tza, bmin: bmina, bmax: bmaxa, keep: ka, od: oa};
        act_b = '{x: txb, y: tyb, z: tzb, bmin: bminb, bmax: bmaxb, keep: kb, od: ob};
    end

    function automatic void chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endfunction

    function automatic void fail_now(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: actual event occurred/expired, required none", nm);
    endfunction

    function automatic void cmp_txn(input string nm, input txn_t act, input txn_t exp);
        if (exp.keep) chk(nm, act, exp);
        else          chk(nm, {act.keep, act.od}, {exp.keep, exp.od});
    endfunction

    function automatic txn_t tri_t(input int x0, y0, z0, x1, y1, z1, x2, y2, z2,
                                   input int mnx, mny, mxx, mxy, input bit od);
        txn_t t;
        t.x[0] = 9'(x0); t.y[0] = 9'(y0); t.z[0] = 9'(z0);
        t.x[1] = 9'(x1); t.y[1] = 9'(y1); t.z[1] = 9'(z1);
        t.x[2] = 9'(x2); t.y[2] = 9'(y2); t.z[2] = 9'(z2);
        t.bmin[1] = 9'(mnx); t.bmin[0] = 9'(mny);
        t.bmax[1] = 9'(mxx); t.bmax[0] = 9'(mxy);
        t.keep = 1'b1;
        t.od   = od;
        return t;
    endfunction

    function automatic txn_t mark_t();
        txn_t t = '0;
        t.od = 1'b1;
        return t;
    endfunction

    // Monitor: every handshake on either instance pops its own expectation queue.
    always @(negedge clk_in) begin
        txn_t e;
        if (rst_in && ready_in) begin
            if (va) begin
                if (q_a.size() == 0) fail_now("unexpected_out_a");
                else begin e = q_a.pop_front(); cmp_txn("txn_a", act_a, e); end
            end
            if (vb) begin
                if (q_b.size() == 0) fail_now("unexpected_out_b");
                else begin e = q_b.pop_front(); cmp_txn("txn_b", act_b, e); end
            end
        end
    end

    task automatic push(input bit to_a, input bit to_b, input txn_t t);
        if (to_a) q_a.push_back(t);
        if (to_b) q_b.push_back(t);
    endtask

    task automatic send(input int x, input int y, input int z, input bit od);
        int n = 0;
        @(negedge clk_in);
        while (!(ra && rb) && n < 50) begin
            @(negedge clk_in);
            n++;
        end
        if (n >= 50) fail_now("send_ready_timeout");
        coor_in[2]  = 9'(x);
        coor_in[1]  = 9'(y);
        coor_in[0]  = 9'(z);
        obj_done_in = od;
        valid_in    = 1'b1;
        @(posedge clk_in);
        #1;
        valid_in    = 1'b0;
        obj_done_in = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        txn_t snap;
        int   seen;
        int   n;

        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        chk("rst_ready", ra, 1);
        chk("rst_valid", va, 0);
        chk("rst_keep", ka, 0);
        chk("rst_od", oa, 0);
        chk("rst_bbox", {bmina, bmaxa}, 0);

        // Counter-clockwise triangle with latency probe
        push(1, 1, tri_t(10, 10, 5, 20, 10, 6, 10, 20, 7, 10, 10, 20, 20, 0));
        send(10, 10, 5, 0);
        send(20, 10, 6, 0);
        send(10, 20, 7, 0);
        chk("lat_area_valid", va, 0);
        chk("lat_area_ready", ra, 0);
        @(posedge clk_in);
        #1;
        chk("lat_out_valid", va, 1);
        repeat (3) @(negedge clk_in);

        // Reversed winding: only the non-culling instance emits
        push(0, 1, tri_t(10, 10, 5, 10, 20, 7, 20, 10, 6, 10, 10, 20, 20, 0));
        send(10, 10, 5, 0);
        send(10, 20, 7, 0);
        send(20, 10, 6, 0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_in);
            seen += int'(va);
        end
        chk("cull_no_out_a", seen, 0);

        // Collinear with object end on third vertex -> marker only
        push(1, 1, mark_t());
        send(0, 0, 1, 0);
        send(5, 5, 2, 0);
        send(10, 10, 3, 1);

        // Object ends on second vertex, then a fresh triangle
        push(1, 1, mark_t());
        send(1, 1, 1, 0);
        send(2, 2, 2, 1);
        push(1, 1, tri_t(10, 10, 5, 20, 10, 6, 10, 20, 7, 10, 10, 20, 20, 1));
        send(10, 10, 5, 0);
        send(20, 10, 6, 0);
        send(10, 20, 7, 1);
        repeat (4) @(negedge clk_in);

        // Downstream stall in OUT with junk vertices offered
        ready_in = 1'b0;
        push(1, 1, tri_t(100, 50, 9, 200, 60, 8, 150, 300, 7, 100, 50, 200, 300, 0));
        send(100, 50, 9, 0);
        send(200, 60, 8, 0);
        send(150, 300, 7, 0);
        n = 0;
        while (!va && n < 10) begin
            @(negedge clk_in);
            n++;
        end
        if (n >= 10) fail_now("stall_valid_timeout");
        snap = act_a;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_in);
            chk("stall_hold", act_a, snap);
            chk("stall_ready", ra, 0);
            coor_in     = {9'(i + 400), 9'(i + 1), 9'(i + 2)};
            obj_done_in = i[0];
            valid_in    = 1'b1;
        end
        @(posedge clk_in);
        #1;
        valid_in    = 1'b0;
        obj_done_in = 1'b0;
        ready_in    = 1'b1;
        @(posedge clk_in);
        #1;
        chk("post_hs_valid", va, 0);
        repeat (2) @(negedge clk_in);

        // Reset after two vertices
        send(7, 8, 9, 0);
        send(11, 12, 13, 0);
        @(negedge clk_in);
        rst_in = 1'b0;
        #1;
        chk("mid_rst_valid", va, 0);
        chk("mid_rst_keep", ka, 0);
        chk("mid_rst_od", oa, 0);
        chk("mid_rst_vtx", {txa, tya, tza}, 0);
        chk("mid_rst_bbox", {bmina, bmaxa}, 0);
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
        repeat (5) @(negedge clk_in);
        push(1, 1, tri_t(0, 0, 0, 300, 0, 0, 0, 200, 0, 0, 0, 300, 200, 0));
        send(0, 0, 0, 0);
        send(300, 0, 0, 0);
        send(0, 200, 0, 0);

        repeat (10) @(negedge clk_in);
        chk("q_a_empty", q_a.size(), 0);
        chk("q_b_empty", q_b.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tri_assemble.md
TRI_ASSEMBLE -- requirements
Module: tri_assemble

Interface
REQ-001 Parameter CULL_BACK, default 1; 1 drops triangles with signed area < 0, 0 keeps them.
REQ-002 clk_in  input  1  single clock, all logic rising-edge.
REQ-003 rst_in  input  1  asynchronous, active-low reset.
REQ-004 coor_in  input  3x9  projected vertex, [2]=x, [1]=y, [0]=z, unsigned screen units.
REQ-005 valid_in  input  1  vertex present on coor_in.
REQ-006 obj_done_in  input  1  this vertex is the last of the object, sampled with valid_in.
REQ-007 ready_out  output  1  block accepts a vertex this cycle.
REQ-008 tri_x_out, tri_y_out, tri_z_out  output  3x9 each  triangle vertices, index 0..2 in arrival order.
REQ-009 bbox_min_out, bbox_max_out  output  2x9 each  [1]=x, [0]=y inclusive bounding box.
REQ-010 tri_keep_out  output  1  1 = real triangle, 0 = end-of-object marker only.
REQ-011 obj_done_out  output  1  transaction closes the object.
REQ-012 valid_out  output  1  output transaction present.
REQ-013 ready_in  input  1  downstream accepts the transaction.

Function
REQ-014 Vertex accepted on a cycle with valid_in && ready_out; valid_in may be a one-cycle pulse.
REQ-015 States COLLECT, AREA, OUT; ready_out = 1 only in COLLECT.
REQ-016 COLLECT: 2-bit vertex counter stores accepted vertex in slot idx, idx increments; on idx==2 acceptance -> AREA, idx -> 0.
REQ-017 AREA (one cycle): area = (x1-x0)(y2-y0) - (x2-x0)(y1-y0), differences 10-bit signed, products 20-bit, area 21-bit signed, no truncation; bbox = per-axis min/max of the three vertices, registered.
REQ-018 Decision after AREA: area==0 -> drop; area<0 && CULL_BACK -> drop; else keep.
REQ-019 Keep -> OUT with tri_keep_out=1, obj_done_out = obj_done of third vertex.
REQ-020 Drop with third-vertex obj_done=0 -> COLLECT, no output; drop with obj_done=1 -> OUT with tri_keep_out=0, obj_done_out=1.
REQ-021 obj_done_in=1 on vertex 0 or 1: partial vertices discarded, idx -> 0, go to OUT with tri_keep_out=0, obj_done_out=1 (skips AREA).
REQ-022 OUT: valid_out=1, all outputs held stable until ready_in; on valid_out && ready_in -> COLLECT, valid_out=0 next cycle.
REQ-023 Latency: third vertex accepted cycle N -> valid_out=1 cycle N+2; throughput limited to one triangle per 5 cycles with ready_in held high.
REQ-024 ready_in=1 while not in OUT has no effect; valid_out never depends combinationally on ready_in.

Reset
REQ-025 rst_in low: state=COLLECT, idx=0, valid_out=0, ready_out=1 (after release), tri_keep_out=0, obj_done_out=0, vertex/bbox registers 0.
REQ-026 Reset mid-triangle or in OUT discards all held data; no transaction emitted after release until three new vertices or an obj_done vertex arrive.

Structure
REQ-027 Shared package holds COORD_W=9, vertex struct (x,y,z), AREA_W=21, state enum.
REQ-028 One sub-module tri_area: combinational signed area and bbox from three vertices, instantiated once.

Verification
REQ-029 v0=(10,10,5), v1=(20,10,6), v2=(10,20,7), ready_in=1 -> valid_out cycle N+2, keep=1, bbox (10,10)-(20,20), obj_done_out=0.
REQ-030 Same vertices order v0,v2,v1, CULL_BACK=1 -> no output; CULL_BACK=0 -> output keep=1.
REQ-031 Collinear (0,0),(5,5),(10,10) with obj_done on third -> one transaction keep=0, obj_done_out=1.
REQ-032 obj_done_in=1 on second vertex -> keep=0, obj_done_out=1; next three vertices form a fresh triangle.
REQ-033 ready_in low 5 cycles in OUT -> outputs constant, ready_out=0, extra valid_in ignored; ready_in high -> single handshake.
REQ-034 rst_in low after two vertices -> outputs at reset values; following triangle (0,0),(300,0),(0,200) -> keep=1, bbox (0,0)-(300,200).
